// File: rtl/ysyx_23060203_icache_pkg.sv
// Shared types and AXI encodings for the set-associative instruction cache.
// Optional feature macro used by the top: YSYX_ICACHE_PERF_EN.
package ysyx_23060203_icache_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        REQ  = 3'b010,
        RESP = 3'b100
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

endpackage

// File: rtl/ysyx_23060203_icache_repl.sv
// Victim selection for the instruction cache: the lowest-index invalid way
// wins, otherwise the per-set round-robin pointer names the victim.
module ysyx_23060203_icache_repl
    import ysyx_23060203_icache_pkg::*;
#(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 2,
    parameter int WAY_W   = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WAYS-1:0]    valid_vec,
    input  logic [INDEX_W-1:0] index,
    input  logic               advance,
    output logic [WAY_W-1:0]   victim,
    output logic               from_rr
);

    localparam int SETS = 1 << INDEX_W;

    logic [WAY_W-1:0] rr_ptr [SETS];

    // Round-robin pointer per set, stepping modulo WAYS when a pointer-chosen victim is filled.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else if (advance) begin
            rr_ptr[index] <= (rr_ptr[index] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[index] + 1'b1;
        end
    end

    // Scan downward so the lowest-index invalid way is the last (winning) assignment.
    always_comb begin
        victim  = rr_ptr[index];
        from_rr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_vec[w]) begin
                victim  = WAY_W'(w);
                from_rr = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ysyx_23060203_icache_sa.sv
// Set-associative instruction cache between the IFU and an AXI read port.
// Combinational lookup; a miss issues one critical-word-first WRAP burst that
// refills a victim way. fence.i during a refill prevents the in-flight line
// from being validated; bad responses or beat counts pulse mem_err.
// Optional: define YSYX_ICACHE_PERF_EN to add saturating perf_hit/perf_miss.
module ysyx_23060203_icache_sa
    import ysyx_23060203_icache_pkg::*;
#(
    parameter int OFFSET_W   = 4,
    parameter int INDEX_W    = 2,
    parameter int WAYS       = 2,
    parameter int TAG_W      = 32 - OFFSET_W - INDEX_W,
    parameter int LINE_WORDS = 1 << (OFFSET_W - 2)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fencei,
    input  logic        req_valid,
    input  logic [31:0] addr,
    output logic        hit,
    output logic [31:0] inst,
    output logic        mem_err,
`ifdef YSYX_ICACHE_PERF_EN
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss,
`endif
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast
);

    localparam int SETS  = 1 << INDEX_W;
    localparam int PTR_W = (OFFSET_W > 2) ? OFFSET_W - 2 : 1;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CNT_W = OFFSET_W;

    // Storage: only the valid bits carry a reset.
    logic              valid_q  [WAYS][SETS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [31:0]       data_mem [WAYS][SETS][LINE_WORDS];

    state_t            state_q, state_d;
    logic [31:0]       req_addr_q;
    logic [WAY_W-1:0]  victim_q;
    logic              victim_rr_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic              err_q;
    logic              kill_q;
    logic              mem_err_q;

    // Address fields of the live fetch and of the latched miss.
    logic [TAG_W-1:0]   look_tag, req_tag;
    logic [INDEX_W-1:0] look_idx, req_idx, repl_idx;
    logic [PTR_W-1:0]   look_off, req_off;

    assign look_tag = addr[31 -: TAG_W];
    assign look_idx = INDEX_W'(addr >> OFFSET_W);
    assign look_off = PTR_W'((addr >> 2) & 32'(LINE_WORDS - 1));
    assign req_tag  = req_addr_q[31 -: TAG_W];
    assign req_idx  = INDEX_W'(req_addr_q >> OFFSET_W);
    assign req_off  = PTR_W'((req_addr_q >> 2) & 32'(LINE_WORDS - 1));

    logic [WAYS-1:0]  match;
    logic [31:0]      hit_word;
    logic [WAYS-1:0]  valid_vec;
    logic [WAY_W-1:0] victim;
    logic             victim_rr;

    logic             miss_start, ar_fire, beat_done, last_beat;
    logic [CNT_W-1:0] cnt_next;
    logic [PTR_W-1:0] ptr_next;
    logic             err_next, kill_next, fill_ok, fill_bad;

    // Tag compare on every way; the matching way's word is OR-merged (at most one matches).
    always_comb begin
        match    = '0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][look_idx] && (tag_mem[w][look_idx] == look_tag)) begin
                match[w] = 1'b1;
                hit_word = hit_word | data_mem[w][look_idx][look_off];
            end
        end
    end

    assign hit  = (state_q == IDLE) && (|match);
    assign inst = hit ? hit_word : '0;

    // Victim choice looks at the fetch set while idle and the refill set afterwards.
    assign repl_idx = (state_q == IDLE) ? look_idx : req_idx;

    // Valid vector of the set the replacement logic is looking at.
    always_comb begin
        valid_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            valid_vec[w] = valid_q[w][repl_idx];
        end
    end

    ysyx_23060203_icache_repl #(
        .WAYS    (WAYS),
        .INDEX_W (INDEX_W),
        .WAY_W   (WAY_W)
    ) u_repl (
        .clock     (clock),
        .reset     (reset),
        .valid_vec (valid_vec),
        .index     (repl_idx),
        .advance   (last_beat && victim_rr_q),
        .victim    (victim),
        .from_rr   (victim_rr)
    );

    assign miss_start = (state_q == IDLE) && req_valid && !hit;
    assign ar_fire    = arvalid && arready;
    assign beat_done  = (state_q == RESP) && rvalid;
    assign last_beat  = beat_done && rlast;

    // Beat counter saturates so an over-long burst can never alias to a good count.
    assign cnt_next  = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + 1'b1;
    assign ptr_next  = (ptr_q == PTR_W'(LINE_WORDS - 1)) ? '0 : ptr_q + 1'b1;
    assign err_next  = err_q || (rresp != RESP_OKAY);
    assign kill_next = kill_q || fencei;
    assign fill_ok   = last_beat && !err_next && !kill_next && (cnt_next == CNT_W'(LINE_WORDS));
    assign fill_bad  = last_beat && (err_next || (cnt_next != CNT_W'(LINE_WORDS)));

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: miss -> address phase -> data phase -> back on the last beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss_start) state_d = REQ;
            REQ:     if (arready)    state_d = RESP;
            RESP:    if (last_beat)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Refill bookkeeping: victim, beat pointer/count, error and kill flags, error pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            victim_q    <= '0;
            victim_rr_q <= 1'b0;
            ptr_q       <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            kill_q      <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            mem_err_q <= fill_bad;
            if (miss_start) begin
                victim_q    <= victim;
                victim_rr_q <= victim_rr;
                kill_q      <= 1'b0;
            end else if (state_q != IDLE) begin
                kill_q <= kill_next;
            end
            if (ar_fire) begin
                ptr_q      <= req_off;
                beat_cnt_q <= '0;
                err_q      <= 1'b0;
            end else if (beat_done) begin
                ptr_q      <= ptr_next;
                beat_cnt_q <= cnt_next;
                err_q      <= err_next;
            end
        end
    end

    // Miss address is a plain datapath latch.
    always_ff @(posedge clock) begin
        if (miss_start) begin
            req_addr_q <= addr;
        end
    end

    // Valid bits: cleared by reset/fence.i, dropped for the victim when its refill starts
    // (its data is about to be overwritten), set only on a clean, unkilled, full refill.
    always_ff @(posedge clock) begin
        if (!reset || fencei) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                end
            end
        end else if (miss_start) begin
            valid_q[victim][look_idx] <= 1'b0;
        end else if (fill_ok) begin
            valid_q[victim_q][req_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: beats land in wrap order starting at the critical word.
    always_ff @(posedge clock) begin
        if (fill_ok) begin
            tag_mem[victim_q][req_idx] <= req_tag;
        end
        if (beat_done) begin
            data_mem[victim_q][req_idx][ptr_q] <= rdata;
        end
    end

    assign arvalid = (state_q == REQ);
    assign araddr  = req_addr_q & ~32'h3;
    assign arid    = 4'd0;
    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = SIZE_4B;
    assign arburst = (LINE_WORDS == 1) ? BURST_INCR : BURST_WRAP;
    assign rready  = (state_q == RESP);
    assign mem_err = mem_err_q;

`ifdef YSYX_ICACHE_PERF_EN
    // Saturating hit/miss event counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_hit  <= '0;
            perf_miss <= '0;
        end else begin
            if (hit && req_valid && (perf_hit != '1)) begin
                perf_hit <= perf_hit + 1'b1;
            end
            if (ar_fire && (perf_miss != '1)) begin
                perf_miss <= perf_miss + 1'b1;
            end
        end
    end
`endif

endmodule
